lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Shares the single LC-3 data memory between two requesters: the CPU memory path (port C, driven from the MAR/MDR sequencing) and the debug/loader port (port D, replacing the free-running direct-access path).
- Serialises accesses through a one-transaction-at-a-time FSM, honours a fixed memory read latency, and gives the CPU priority with a starvation guard for debug.
- Sits between the Memory block's storage array and the two requesters.

Parameters:
- AW, 16, address width
- DW, 16, data width
- MEM_LAT, 1, memory read latency in cycles from mem_en cycle to mem_rdata valid; legal range is 1..15
- STARVE_LIMIT, 4, consecutive contested losses by port D before port D is forced to win; legal range is 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- c_req  in  1  CPU request; held with c_we/c_addr/c_wdata stable until c_ack
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_ack  out  1  one-cycle completion pulse to CPU
- c_rdata  out  DW  CPU read data, valid while c_ack=1
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug port, same rules as CPU
- d_ack  out  1  debug completion pulse
- d_rdata  out  DW  debug read data, valid while d_ack=1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in any state other than IDLE
- grant_d  out  1  owner of the current transaction (0=C, 1=D); holds its last value in IDLE

Behaviour:
- All outputs are registered. On reset every output is 0, the state is IDLE, and the starve counter is 0.
- States and transitions:
  - IDLE: sample c_req/d_req. If either is high, latch the winner's we/addr/wdata into the mem_* registers and go to ACCESS.
  - ACCESS: 1 cycle, mem_en=1. Next state is ACK for a write, WAIT for a read.
  - WAIT: exactly MEM_LAT cycles. mem_rdata is captured on the last WAIT cycle. Next state is ACK.
  - ACK: 1 cycle. The owner's ack=1 and its rdata holds the captured data (rdata holds 0 for writes). Next state is IDLE.
- Timing, with the request sampled in IDLE cycle 0:
  - writes: ACCESS in cycle 1, ack in cycle 2
  - reads: ack in cycle 2+MEM_LAT
  - minimum back-to-back spacing between one ack and the next is 2 cycles (IDLE then ACCESS)
- Requester rule: deassert req in the cycle after ack. A req high in IDLE is always a new transaction. req/attribute changes outside IDLE are ignored.
- Arbitration, evaluated only in IDLE:
  - only one req high: that port wins.
  - both high and starve_cnt < STARVE_LIMIT: C wins, starve_cnt increments.
  - both high and starve_cnt == STARVE_LIMIT: D wins.
  - starve_cnt is cleared on any D grant and does not change on an uncontested C grant.
- mem_en is low in every state except ACCESS. mem_addr, mem_we and mem_wdata hold their values until the next latch.
- Non-owner ack stays 0 throughout.
- Reset mid-operation: the FSM goes to IDLE on the next edge and no ack is issued. A write whose ACCESS cycle coincides with reset is still performed by memory. Requesters must reissue.
- There is no error path. Out-of-range parameters are rejected at elaboration.

Decomposition:
- Shared package lc3_mem_pkg holds:
  - state enum {IDLE, ACCESS, WAIT, ACK}
  - requester ID constants REQ_C=0, REQ_D=1
  - latency counter width constant (4 bits)
- One natural sub-module, lc3_starve_ctr: the saturating contested-loss counter plus the winner-select logic. It takes c_req, d_req and a decide strobe, and outputs winner_d.
- The FSM, latency counter and data registers stay in the top level.

Test Plan:
- Single CPU write, c_addr=0x3000, c_wdata=0x1234 -> mem_en/mem_we high in cycle 1 with those values; c_ack in cycle 2; d_ack stays 0.
- CPU read of 0x3000 after the write, MEM_LAT=1 -> c_ack in cycle 3 with c_rdata=0x1234. Repeat with MEM_LAT=3 -> c_ack in cycle 5.
- c_req and d_req both held continuously, STARVE_LIMIT=4 -> grant order C,C,C,C,D,C,C,C,C,D. Each ack is 2 cycles (writes) after its IDLE decision.
- d_req alone, read of 0x0000 -> D serviced immediately, grant_d=1, starve_cnt stays 0.
- Reset asserted during WAIT of a CPU read -> next cycle busy=0 and all outputs 0; no c_ack is ever issued; a reissued read completes normally.
- Both requests arrive the same cycle the arbiter leaves ACK -> decision happens in the following IDLE cycle, and no request is lost or acked twice.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC-3 data-memory arbiter: FSM states, requester IDs, counter widths.
// Pure declarations, no logic.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK
  } state_t;

  localparam logic REQ_C = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Wide enough for MEM_LAT and STARVE_LIMIT, both capped at 15
  localparam int LAT_W   = 4;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/lc3_starve_ctr.sv
// Winner select for the C/D requesters: C has priority, D is forced through after STARVE_LIMIT contested losses.
// winner_d is combinational from the requests; the loss counter updates only on a decide strobe.
module lc3_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic c_req,
  input  logic d_req,
  input  logic decide,
  output logic winner_d
);
  import lc3_mem_pkg::*;

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;

  always_comb begin
    winner_d = d_req && (!c_req || (starve_cnt == LIMIT));
  end

  // Never exceeds LIMIT: reaching it hands the next contest to D, which clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (decide) begin
      if (winner_d) begin
        starve_cnt <= '0;
      end else if (c_req && d_req) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Serialises CPU (C) and debug (D) accesses to the LC-3 data memory, one transaction at a time.
// Write ack 2 cycles after the IDLE decision, read ack 2+MEM_LAT; requesters hold req until ack.
module lc3_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_d
);
  import lc3_mem_pkg::*;

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("lc3_mem_arbiter: MEM_LAT must be in 1..15");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("lc3_mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             decide;
  logic             winner_d;
  logic             finish;
  logic [DW-1:0]    finish_data;

  assign decide = (state == IDLE) && (c_req || d_req);

  lc3_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .c_req   (c_req),
    .d_req   (d_req),
    .decide  (decide),
    .winner_d(winner_d)
  );

  // Last cycle before ACK: the write's ACCESS cycle or the read's final WAIT cycle
  always_comb begin
    finish      = ((state == ACCESS) && mem_we) || ((state == WAIT) && (lat_cnt == LAT_LAST));
    finish_data = (state == WAIT) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      c_ack     <= 1'b0;
      c_rdata   <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      grant_d   <= 1'b0;
    end else begin
      mem_en <= decide;
      c_ack  <= finish && (grant_d == REQ_C);
      d_ack  <= finish && (grant_d == REQ_D);

      if (finish) begin
        if (grant_d == REQ_D) d_rdata <= finish_data;
        else                  c_rdata <= finish_data;
      end else if (state == ACK) begin
        c_rdata <= '0;
        d_rdata <= '0;
      end

      case (state)
        IDLE: begin
          if (decide) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            grant_d   <= winner_d;
            mem_we    <= winner_d ? d_we    : c_we;
            mem_addr  <= winner_d ? d_addr  : c_addr;
            mem_wdata <= winner_d ? d_wdata : c_wdata;
          end
        end
        ACCESS: begin
          lat_cnt <= '0;
          state   <= mem_we ? ACK : WAIT;
        end
        WAIT: begin
          if (finish) state <= ACK;
          else        lat_cnt <= lat_cnt + 1'b1;
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Two instances: MEM_LAT=1 (main) and MEM_LAT=3 (read latency check).
module tb_lc3_mem_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int SL   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        c_req, c_we, c_ack, d_req, d_we, d_ack;
  logic [15:0] c_addr, c_wdata, c_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, busy, grant_d;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        c3_req, c3_we, c3_ack, d3_req, d3_we, d3_ack;
  logic [15:0] c3_addr, c3_wdata, c3_rdata, d3_addr, d3_wdata, d3_rdata;
  logic        m3_en, m3_we, busy3, grant3;
  logic [15:0] m3_addr, m3_wdata, m3_rdata;

  lc3_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_d(grant_d)
  );

  lc3_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT3), .STARVE_LIMIT(SL)) dut3 (
    .clk(clk), .reset(reset),
    .c_req(c3_req), .c_we(c3_we), .c_addr(c3_addr), .c_wdata(c3_wdata), .c_ack(c3_ack), .c_rdata(c3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata), .d_ack(d3_ack), .d_rdata(d3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_rdata(m3_rdata),
    .busy(busy3), .grant_d(grant3)
  );

  // Memory models: unwritten locations read as 0; read data valid exactly LAT cycles after mem_en
  logic [15:0] mem1 [logic [15:0]];
  logic [15:0] mem3 [logic [15:0]];
  logic [15:0] shadow [logic [15:0]];
  logic [LAT-1:0]  v1 = '0;
  logic [15:0]     d1 [LAT];
  logic [LAT3-1:0] v3 = '0;
  logic [15:0]     d3 [LAT3];

  function automatic logic [15:0] rd_m1(input logic [15:0] a);
    return mem1.exists(a) ? mem1[a] : 16'h0000;
  endfunction
  function automatic logic [15:0] rd_m3(input logic [15:0] a);
    return mem3.exists(a) ? mem3[a] : 16'h0000;
  endfunction
  function automatic logic [15:0] rd_sh(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : 16'h0000;
  endfunction

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      v1[i] <= v1[i-1];
      d1[i] <= d1[i-1];
    end
    v1[0] <= mem_en && !mem_we;
    d1[0] <= rd_m1(mem_addr);
    if (mem_en && mem_we) mem1[mem_addr] = mem_wdata;
  end
  assign mem_rdata = v1[LAT-1] ? d1[LAT-1] : 16'hBAD0;

  always @(posedge clk) begin
    for (int i = LAT3 - 1; i > 0; i--) begin
      v3[i] <= v3[i-1];
      d3[i] <= d3[i-1];
    end
    v3[0] <= m3_en && !m3_we;
    d3[0] <= rd_m3(m3_addr);
    if (m3_en && m3_we) mem3[m3_addr] = m3_wdata;
  end
  assign m3_rdata = v3[LAT3-1] ? d3[LAT3-1] : 16'hBAD3;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Steps n negedges; the ack must appear on the last one only, from the expected owner
  task automatic wait_ack(input bit exp_d, input int n, input logic [15:0] exp_rd, input string tag);
    bit early = 1'b0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (k < n && (c_ack || d_ack)) early = 1'b1;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_ack"}, {30'd0, c_ack, d_ack}, exp_d ? 32'd1 : 32'd2);
    chk({tag, "_rdata"}, 32'(exp_d ? d_rdata : c_rdata), 32'(exp_rd));
    chk({tag, "_grant"}, 32'(grant_d), 32'(exp_d));
  endtask

  task automatic new_c();
    c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
    c_addr = {12'h500, 4'($urandom_range(0, 15))}; c_wdata = 16'($urandom);
  endtask
  task automatic new_d();
    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
    d_addr = {12'h500, 4'($urandom_range(0, 15))}; d_wdata = 16'($urandom);
  endtask

  bit          pc, pd, win_d, saw;
  int          m_starve;
  bit          exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  logic [15:0] exp_rd;

  initial begin
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
    d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;
    repeat (3) step();
    chk("rst_ctl", {26'd0, c_ack, d_ack, mem_en, mem_we, busy, grant_d}, 32'd0);
    chk("rst_rdata", {c_rdata, d_rdata}, 32'd0);
    chk("rst_mem", {mem_addr, mem_wdata}, 32'd0);
    reset = 1'b0;
    step();

    // Single CPU write
    c_req = 1; c_we = 1; c_addr = 16'h3000; c_wdata = 16'h1234;
    step();
    chk("wr_access", {30'd0, mem_en, mem_we}, 32'd3);
    chk("wr_mem", {mem_addr, mem_wdata}, 32'h3000_1234);
    chk("wr_busy", 32'(busy), 32'd1);
    wait_ack(0, 1, 16'h0000, "wr");
    c_req = 0;
    step();
    chk("idle_hold", {14'd0, mem_en, busy, mem_addr}, 32'h0000_3000);

    // CPU read-back, ack in cycle 2+LAT
    c_req = 1; c_we = 0;
    wait_ack(0, 2 + LAT, 16'h1234, "rd");
    c_req = 0;
    step();

    // Debug read alone
    d_req = 1; d_we = 0; d_addr = 16'h0000;
    step();
    chk("drd_grant", {15'd0, grant_d, mem_addr}, 32'h0001_0000);
    wait_ack(1, 1 + LAT, 16'h0000, "drd");
    d_req = 0;
    step();

    // Both held continuously: C x4, then D
    c_req = 1; c_we = 1; c_addr = 16'h3100; c_wdata = 16'hC0C0;
    d_req = 1; d_we = 1; d_addr = 16'h3200; d_wdata = 16'hD0D0;
    for (int k = 0; k < 10; k++) begin
      wait_ack(exp_order[k], (k == 0) ? 2 : 3, 16'h0000, $sformatf("arb%0d", k));
    end
    c_req = 0; d_req = 0;
    step();

    // Reset during the WAIT of a CPU read
    c_req = 1; c_we = 0; c_addr = 16'h3000;
    step();
    step();
    reset = 1; c_req = 0;
    step();
    chk("midrst_ctl", {26'd0, c_ack, d_ack, mem_en, mem_we, busy, grant_d}, 32'd0);
    chk("midrst_mem", {mem_addr, c_rdata}, 32'd0);
    reset = 0;
    saw = 0;
    repeat (5) begin
      step();
      saw = saw | c_ack | d_ack;
    end
    chk("midrst_noack", 32'(saw), 32'd0);
    c_req = 1; c_we = 0; c_addr = 16'h3000;
    wait_ack(0, 2 + LAT, 16'h1234, "reissue");
    c_req = 0;
    step();

    // Both requests arrive during the ACK cycle
    c_req = 1; c_we = 1; c_addr = 16'h3300; c_wdata = 16'h5555;
    wait_ack(0, 2, 16'h0000, "pre");
    c_addr = 16'h4000; c_wdata = 16'hAAAA;
    d_req = 1; d_we = 1; d_addr = 16'h4001; d_wdata = 16'hBEEF;
    wait_ack(0, 3, 16'h0000, "ackc");
    c_req = 0;
    wait_ack(1, 3, 16'h0000, "ackd");
    d_req = 0;
    saw = 0;
    repeat (5) begin
      step();
      saw = saw | c_ack | d_ack;
    end
    chk("ack_once", 32'(saw), 32'd0);
    c_req = 1; c_we = 0; c_addr = 16'h4001;
    wait_ack(0, 2 + LAT, 16'hBEEF, "rb4001");
    c_addr = 16'h4000;
    step();
    c_req = 1;
    wait_ack(0, 2 + LAT, 16'hAAAA, "rb4000");
    c_req = 0;
    step();

    // MEM_LAT=3 instance: write then read, ack in cycle 5
    c3_req = 1; c3_we = 1; c3_addr = 16'h3000; c3_wdata = 16'h1234;
    step();
    step();
    chk("l3_wr_ack", {31'd0, c3_ack}, 32'd1);
    c3_req = 0;
    step();
    c3_req = 1; c3_we = 0;
    saw = 0;
    for (int k = 1; k < 2 + LAT3; k++) begin
      step();
      saw = saw | c3_ack;
    end
    chk("l3_early", 32'(saw), 32'd0);
    step();
    chk("l3_rd_ack", {15'd0, c3_ack, c3_rdata}, 32'h0001_1234);
    c3_req = 0;
    chk("l3_d_idle", {15'd0, d3_ack, d3_rdata}, 32'd0);
    chk("l3_grant", {30'd0, busy3, grant3}, 32'd2);

    // Randomized traffic against the transaction-level model
    reset = 1;
    step();
    reset = 0;
    step();
    m_starve = 0;
    pc = 0; pd = 0;
    for (int t = 0; t < 80; t++) begin
      if (!pc && $urandom_range(0, 9) < 7) begin new_c(); pc = 1; end
      if (!pd && $urandom_range(0, 9) < 6) begin new_d(); pd = 1; end
      if (!pc && !pd) begin new_c(); pc = 1; end
      if (pc && pd) begin
        win_d = (m_starve == SL);
        m_starve = win_d ? 0 : m_starve + 1;
      end else begin
        win_d = pd;
        if (pd) m_starve = 0;
      end
      if (win_d) begin
        exp_rd = d_we ? 16'h0000 : rd_sh(d_addr);
        wait_ack(1, d_we ? 2 : 2 + LAT, exp_rd, $sformatf("rnd%0d", t));
        if (d_we) shadow[d_addr] = d_wdata;
        d_req = 0; pd = 0;
      end else begin
        exp_rd = c_we ? 16'h0000 : rd_sh(c_addr);
        wait_ack(0, c_we ? 2 : 2 + LAT, exp_rd, $sformatf("rnd%0d", t));
        if (c_we) shadow[c_addr] = c_wdata;
        c_req = 0; pc = 0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
